rtc_set_controller: RTL and testbench

Time-set sequencer for the HH:MM:SS real-time clock on the DE2-115 board. It debounces the three raw push buttons and synchronizes the manual-set switch. It runs a field-select state machine and issues single-cycle increment/decrement strobes, with auto-repeat, to the hour, minute and second counters. It sits between the board inputs and the RTC counter datapath, and also drives the counter run-enable, prescaler clear and display blink.

---
 rtl/rtc_set_controller.sv | 206 ++++++++++++++++++++
 tb/tb_rtc_set_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_set_controller.sv
// Time-set sequencer for the HH:MM:SS RTC: button debounce, switch sync,
// field-select FSM, inc/dec strobes with auto-repeat, and set-mode blink.
module rtc_set_controller #(
  parameter int unsigned DEBOUNCE_DIV = 49999,
  parameter int unsigned DEBOUNCE_LEN = 8,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned BLINK_DIV    = 12499999
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic       man_switch,
  input  logic [2:0] push_button,
  output logic       run_en,
  output logic [1:0] field_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       prescale_clr,
  output logic       blink,
  output logic [2:0] btn_level
);

  localparam int unsigned TW = (DEBOUNCE_DIV > 0) ? $clog2(DEBOUNCE_DIV + 1) : 1;
  localparam int unsigned RW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam int unsigned BW = (BLINK_DIV > 0) ? $clog2(BLINK_DIV + 1) : 1;
  localparam int unsigned BTN_UP  = 0;
  localparam int unsigned BTN_DN  = 1;
  localparam int unsigned BTN_SEL = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SET_HH = 2'd1,
    ST_SET_MM = 2'd2,
    ST_SET_SS = 2'd3
  } state_e;

  // input conditioning
  logic [2:0]                   btn_meta_q, btn_sync_q;
  logic                         sw_meta_q, sw_sync_q;
  logic [TW-1:0]                tick_cnt_q, tick_cnt_d;
  logic                         tick_c;
  logic [2:0][DEBOUNCE_LEN-1:0] shift_q, shift_d;
  logic [2:0]                   level_q, level_d;
  logic [2:0]                   level_prev_q;
  logic [2:0]                   press_c;

  // control
  state_e        state_q, state_d;
  logic          lock_q, lock_d, lock_c, hold_one_c;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [RW:0]   rpt_inc_c;
  logic          rpt_phase_q, rpt_phase_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          run_en_q, run_en_d;
  logic [1:0]    field_sel_q, field_sel_d;
  logic          inc_q, inc_d, dec_q, dec_d, clr_q, clr_d;

  assign run_en       = run_en_q;
  assign field_sel    = field_sel_q;
  assign inc_pulse    = inc_q;
  assign dec_pulse    = dec_q;
  assign prescale_clr = clr_q;
  assign blink        = blink_q;
  assign btn_level    = level_q;

  // Synchronizers, sample tick and debounce registers
  always_ff @(posedge clk50M) begin
    if (reset) begin
      btn_meta_q   <= '1;
      btn_sync_q   <= '1;
      sw_meta_q    <= 1'b0;
      sw_sync_q    <= 1'b0;
      tick_cnt_q   <= '0;
      shift_q      <= '1;
      level_q      <= '0;
      level_prev_q <= '0;
    end else begin
      btn_meta_q   <= push_button;
      btn_sync_q   <= btn_meta_q;
      sw_meta_q    <= man_switch;
      sw_sync_q    <= sw_meta_q;
      tick_cnt_q   <= tick_cnt_d;
      shift_q      <= shift_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign tick_c     = (tick_cnt_q == TW'(DEBOUNCE_DIV));
  assign tick_cnt_d = tick_c ? '0 : tick_cnt_q + TW'(1);
  assign press_c    = level_q & ~level_prev_q;

  // Buttons are active-low: a full run of 0s means pressed, of 1s released
  always_comb begin
    shift_d = shift_q;
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      if (tick_c) begin
        shift_d[i] = {shift_q[i][DEBOUNCE_LEN-2:0], btn_sync_q[i]};
      end
      if (shift_d[i] == '0) begin
        level_d[i] = 1'b1;
      end else if (&shift_d[i]) begin
        level_d[i] = 1'b0;
      end
    end
  end

  // Field-select FSM; a switch drop outranks a select press
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (sw_sync_q) state_d = ST_SET_HH;
      ST_SET_HH: if (!sw_sync_q) state_d = ST_RUN;
                 else if (press_c[BTN_SEL]) state_d = ST_SET_MM;
      ST_SET_MM: if (!sw_sync_q) state_d = ST_RUN;
                 else if (press_c[BTN_SEL]) state_d = ST_SET_SS;
      ST_SET_SS: if (!sw_sync_q) state_d = ST_RUN;
                 else if (press_c[BTN_SEL]) state_d = ST_SET_HH;
      default:   state_d = ST_RUN;
    endcase
  end

  // Strobes and auto-repeat; only in a SET state that is not changing this cycle
  always_comb begin
    inc_d       = 1'b0;
    dec_d       = 1'b0;
    rpt_cnt_d   = '0;
    rpt_phase_d = 1'b0;
    rpt_inc_c   = '0;
    lock_c      = lock_q | (level_q[BTN_UP] & level_q[BTN_DN]);
    lock_d      = lock_c & (level_q[BTN_UP] | level_q[BTN_DN]);
    hold_one_c  = level_q[BTN_UP] ^ level_q[BTN_DN];
    if ((state_q != ST_RUN) && (state_d == state_q) && !lock_c) begin
      if (press_c[BTN_UP] | press_c[BTN_DN]) begin
        inc_d = press_c[BTN_UP];
        dec_d = press_c[BTN_DN];
      end else if (hold_one_c) begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
        if (tick_c) begin
          rpt_inc_c = {1'b0, rpt_cnt_q} + (RW+1)'(1);
          if ((!rpt_phase_q && (rpt_inc_c == (RW+1)'(REPEAT_DELAY))) ||
              ( rpt_phase_q && (rpt_inc_c == (RW+1)'(REPEAT_RATE)))) begin
            inc_d       = level_q[BTN_UP];
            dec_d       = level_q[BTN_DN];
            rpt_cnt_d   = '0;
            rpt_phase_d = 1'b1;
          end else begin
            rpt_cnt_d = rpt_inc_c[RW-1:0];
          end
        end
      end
    end
  end

  // Blink restarts dark on every state or field change
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if ((state_q != ST_RUN) && (state_d == state_q)) begin
      if (blink_cnt_q == BW'(BLINK_DIV)) begin
        blink_d = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_d     = blink_q;
      end
    end
  end

  always_comb begin
    run_en_d    = (state_d == ST_RUN);
    field_sel_d = 2'(state_d);
    clr_d       = (state_q != ST_RUN) && (state_d == ST_RUN);
  end

  always_ff @(posedge clk50M) begin
    if (reset) begin
      state_q     <= ST_RUN;
      lock_q      <= 1'b0;
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      run_en_q    <= 1'b1;
      field_sel_q <= 2'd0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      run_en_q    <= run_en_d;
      field_sel_q <= field_sel_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      clr_q       <= clr_d;
    end
  end

endmodule

// File: tb/tb_rtc_set_controller.sv
// Directed self-checking bench for rtc_set_controller with short timing parameters.
module tb_rtc_set_controller;

  logic       clk50M;
  logic       reset;
  logic       man_switch;
  logic [2:0] push_button;
  logic       run_en;
  logic [1:0] field_sel;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       prescale_clr;
  logic       blink;
  logic [2:0] btn_level;

  int checks;
  int passed;

  rtc_set_controller #(
    .DEBOUNCE_DIV(3),
    .DEBOUNCE_LEN(4),
    .REPEAT_DELAY(6),
    .REPEAT_RATE (2),
    .BLINK_DIV   (15)
  ) dut (
    .clk50M      (clk50M),
    .reset       (reset),
    .man_switch  (man_switch),
    .push_button (push_button),
    .run_en      (run_en),
    .field_sel   (field_sel),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .prescale_clr(prescale_clr),
    .blink       (blink),
    .btn_level   (btn_level)
  );

  initial clk50M = 1'b0;
  always #5 clk50M = ~clk50M;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk50M);
      #1;
    end
  endtask

  task automatic press_btn(input int idx, input int hold, input int rel);
    push_button[idx] = 1'b0;
    step(hold);
    push_button[idx] = 1'b1;
    step(rel);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    man_switch = 1'b0;
    push_button = 3'b111;
    step(3);
    checks++; if (run_en !== 1'b1) $display("FAIL reset_run_en: got %b want 1", run_en); else passed++;
    checks++; if (field_sel !== 2'd0) $display("FAIL reset_field_sel: got %0d want 0", field_sel); else passed++;
    checks++; if (blink !== 1'b0) $display("FAIL reset_blink: got %b want 0", blink); else passed++;
    checks++; if (btn_level !== 3'b000) $display("FAIL reset_btn_level: got %b want 000", btn_level); else passed++;
    checks++; if ({inc_pulse, dec_pulse, prescale_clr} !== 3'b000)
      $display("FAIL reset_strobes: got %b want 000", {inc_pulse, dec_pulse, prescale_clr}); else passed++;
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_switch();
    man_switch = 1'b1;
    step(2);
    checks++; if (field_sel !== 2'd0) $display("FAIL sw_entry_early: got %0d want 0", field_sel); else passed++;
    step(1);
    checks++; if ({run_en, field_sel} !== 3'b001)
      $display("FAIL sw_entry: got run_en=%b field=%0d want run_en=0 field=1", run_en, field_sel); else passed++;
    man_switch = 1'b0;
    step(2);
    checks++; if ({prescale_clr, field_sel} !== 3'b001)
      $display("FAIL sw_exit_early: got clr=%b field=%0d want clr=0 field=1", prescale_clr, field_sel); else passed++;
    step(1);
    checks++; if ({run_en, field_sel, prescale_clr} !== 4'b1001)
      $display("FAIL sw_exit: got run_en=%b field=%0d clr=%b want 1/0/1", run_en, field_sel, prescale_clr); else passed++;
    step(1);
    checks++; if (prescale_clr !== 1'b0) $display("FAIL sw_clr_width: got %b want 0", prescale_clr); else passed++;
  endtask

  task automatic test_debounce();
    int changes;
    logic [1:0] prev;
    logic [1:0] exp_seq [3];
    exp_seq = '{2'd2, 2'd3, 2'd1};
    man_switch = 1'b1;
    step(4);
    checks++; if (field_sel !== 2'd1) $display("FAIL db_enter: got %0d want 1", field_sel); else passed++;
    prev = field_sel;
    changes = 0;
    for (int i = 0; i < 8; i++) begin
      push_button[2] = (i % 2 == 1);
      for (int j = 0; j < 5; j++) begin
        step(1);
        if (field_sel !== prev) begin changes++; prev = field_sel; end
      end
    end
    push_button[2] = 1'b0;
    for (int j = 0; j < 40; j++) begin
      step(1);
      if (field_sel !== prev) begin changes++; prev = field_sel; end
    end
    push_button[2] = 1'b1;
    for (int j = 0; j < 30; j++) begin
      step(1);
      if (field_sel !== prev) begin changes++; prev = field_sel; end
    end
    checks++; if (changes !== 1) $display("FAIL db_bounce_changes: got %0d want 1", changes); else passed++;
    checks++; if (field_sel !== 2'd2) $display("FAIL db_bounce_field: got %0d want 2", field_sel); else passed++;
    man_switch = 1'b0;
    step(4);
    man_switch = 1'b1;
    step(4);
    checks++; if (field_sel !== 2'd1) $display("FAIL db_reenter: got %0d want 1", field_sel); else passed++;
    for (int k = 0; k < 3; k++) begin
      press_btn(2, 30, 30);
      checks++; if (field_sel !== exp_seq[k])
        $display("FAIL db_cycle_%0d: got %0d want %0d", k, field_sel, exp_seq[k]); else passed++;
    end
  endtask

  task automatic test_autorepeat();
    bit found;
    int errs, cnt, dec_seen, quiet;
    bit exp_inc;
    press_btn(2, 30, 30);
    checks++; if (field_sel !== 2'd2) $display("FAIL rpt_field: got %0d want 2", field_sel); else passed++;
    push_button[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (inc_pulse === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) $display("FAIL rpt_first: got no inc_pulse want one within 40 cycles"); else passed++;
    errs = 0; cnt = 0; dec_seen = 0;
    for (int off = 1; off <= 76; off++) begin
      step(1);
      exp_inc = (off >= 23) && ((off - 23) % 8 == 0);
      if (inc_pulse !== exp_inc) errs++;
      if (inc_pulse === 1'b1) cnt++;
      if (dec_pulse !== 1'b0) dec_seen++;
    end
    checks++; if (errs !== 0) $display("FAIL rpt_pattern: got %0d misplaced cycles want 0", errs); else passed++;
    checks++; if (cnt !== 7) $display("FAIL rpt_count: got %0d repeats want 7", cnt); else passed++;
    checks++; if (dec_seen !== 0) $display("FAIL rpt_no_dec: got %0d dec cycles want 0", dec_seen); else passed++;
    push_button[0] = 1'b1;
    step(40);
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (inc_pulse | dec_pulse) quiet++;
    end
    checks++; if (quiet !== 0) $display("FAIL rpt_release: got %0d strobes want 0", quiet); else passed++;
  endtask

  task automatic test_conflicts();
    bit found;
    int strobes, cnt;
    logic [1:0] prev;
    push_button[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (inc_pulse === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) $display("FAIL cf_up_first: got no inc_pulse want one"); else passed++;
    push_button[1] = 1'b0;
    strobes = 0;
    for (int i = 0; i < 60; i++) begin step(1); if (inc_pulse | dec_pulse) strobes++; end
    push_button[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin step(1); if (inc_pulse | dec_pulse) strobes++; end
    push_button[1] = 1'b1;
    for (int i = 0; i < 30; i++) begin step(1); if (inc_pulse | dec_pulse) strobes++; end
    checks++; if (strobes !== 0) $display("FAIL cf_both_held: got %0d strobes want 0", strobes); else passed++;
    cnt = 0;
    push_button[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin step(1); if (inc_pulse === 1'b1) cnt++; end
    push_button[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin step(1); if (inc_pulse === 1'b1) cnt++; end
    checks++; if (cnt !== 1) $display("FAIL cf_unlock: got %0d inc want 1", cnt); else passed++;
    prev = field_sel;
    cnt = 0;
    push_button = 3'b010;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (inc_pulse === 1'b1) cnt++;
      if (field_sel !== prev) break;
    end
    push_button = 3'b111;
    for (int i = 0; i < 30; i++) begin step(1); if (inc_pulse === 1'b1) cnt++; end
    checks++; if (field_sel !== 2'd3) $display("FAIL cf_sel_up_field: got %0d want 3", field_sel); else passed++;
    checks++; if (cnt !== 0) $display("FAIL cf_sel_up_inc: got %0d inc want 0", cnt); else passed++;
    man_switch = 1'b0;
    step(4);
    checks++; if (run_en !== 1'b1) $display("FAIL cf_run: got %b want 1", run_en); else passed++;
    cnt = 0;
    push_button[0] = 1'b0;
    for (int i = 0; i < 25; i++) begin step(1); if (inc_pulse | dec_pulse) cnt++; end
    checks++; if (btn_level !== 3'b001) $display("FAIL cf_run_level: got %b want 001", btn_level); else passed++;
    push_button[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin step(1); if (inc_pulse | dec_pulse) cnt++; end
    checks++; if (cnt !== 0) $display("FAIL cf_run_strobe: got %0d strobes want 0", cnt); else passed++;
  endtask

  task automatic test_blink_and_reset();
    bit found;
    logic nv;
    logic prev;
    man_switch = 1'b1;
    step(4);
    press_btn(2, 30, 30);
    press_btn(2, 30, 30);
    checks++; if (field_sel !== 2'd3) $display("FAIL bl_field_ss: got %0d want 3", field_sel); else passed++;
    prev = blink;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (blink !== prev) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) $display("FAIL bl_toggle_seen: got no toggle want one within 40 cycles"); else passed++;
    nv = blink;
    step(15);
    checks++; if (blink !== nv) $display("FAIL bl_period_hold: got %b want %b", blink, nv); else passed++;
    step(1);
    checks++; if (blink !== ~nv) $display("FAIL bl_period_toggle: got %b want %b", blink, ~nv); else passed++;
    push_button[2] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (field_sel !== 2'd3) break;
    end
    checks++; if ({field_sel, blink} !== 3'b010)
      $display("FAIL bl_field_change: got field=%0d blink=%b want field=1 blink=0", field_sel, blink); else passed++;
    step(15);
    checks++; if (blink !== 1'b0) $display("FAIL bl_restart_hold: got %b want 0", blink); else passed++;
    step(1);
    checks++; if (blink !== 1'b1) $display("FAIL bl_restart_toggle: got %b want 1", blink); else passed++;
    push_button[2] = 1'b1;
    step(30);
    push_button[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (inc_pulse === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) $display("FAIL mr_first: got no inc_pulse want one"); else passed++;
    step(30);
    reset = 1'b1;
    step(1);
    checks++; if ({inc_pulse, dec_pulse, prescale_clr, blink} !== 4'b0000)
      $display("FAIL mr_strobes: got %b want 0000", {inc_pulse, dec_pulse, prescale_clr, blink}); else passed++;
    checks++; if ({run_en, field_sel, btn_level} !== 6'b100000)
      $display("FAIL mr_state: got run_en=%b field=%0d level=%b want 1/0/000", run_en, field_sel, btn_level); else passed++;
    reset = 1'b0;
    step(10);
    checks++; if (btn_level !== 3'b000) $display("FAIL mr_redebounce_early: got %b want 000", btn_level); else passed++;
    step(15);
    checks++; if (btn_level !== 3'b001) $display("FAIL mr_redebounce_late: got %b want 001", btn_level); else passed++;
    push_button = 3'b111;
    step(30);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_switch();
    test_debounce();
    test_autorepeat();
    test_conflicts();
    test_blink_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
